// File: rtl/gyro_motion_detector.sv
// Purpose : turns gyro angular-rate samples into a debounced one-cycle "mover" pulse
//           (magnitude threshold, N consecutive hits, then a cooldown window).
// Latency : mover rises 1 cycle after the sample_valid that carried the final hit.
// Backpres: none; samples are strobed in and simply ignored outside ARMED/COUNTING.
//
// Ports:
//   clk               system clock (50 MHz)
//   reset             synchronous, active-low; clears all state
//   enable_giroscopio block enable; low forces IDLE and flushes the hit count
//   sample_valid      one-cycle strobe qualifying sample_data
//   sample_data       signed angular rate (two's complement, DATA_W bits)
//   mover             one-cycle pulse on detected movement
//   moving            level, high from the fire cycle until the cooldown ends
//   mover_dir         (only with GYRO_DIRECTION_EN) 1 = positive rotation at last fire
//   hit_cnt           current consecutive-hit count
//
// Optional feature macro: GYRO_DIRECTION_EN -- consecutive hits must share sign and
// the sign of the firing run is reported on mover_dir.

module gyro_motion_detector #(
  parameter int DATA_W          = 16,
  parameter int THRESHOLD       = 2000,
  parameter int HIT_COUNT       = 3,
  parameter int COOLDOWN_CYCLES = 25000000,
  parameter int CNT_W           = 25
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable_giroscopio,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample_data,
  output logic                     mover,
  output logic                     moving,
`ifdef GYRO_DIRECTION_EN
  output logic                     mover_dir,
`endif
  output logic [3:0]               hit_cnt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARMED    = 3'd1;
  localparam logic [2:0] S_COUNTING = 3'd2;
  localparam logic [2:0] S_FIRE     = 3'd3;
  localparam logic [2:0] S_COOLDOWN = 3'd4;

  localparam logic [DATA_W-1:0] THR_L   = DATA_W'(THRESHOLD);
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] ZERO_D  = '0;
  localparam logic [3:0]        HIT_L   = 4'(HIT_COUNT);
  // Loading COOLDOWN_CYCLES-1 makes the FIRE cycle plus the countdown span
  // exactly COOLDOWN_CYCLES+1 cycles of moving.
  localparam logic [CNT_W-1:0]  CD_LOAD = (COOLDOWN_CYCLES > 0) ?
                                          CNT_W'(COOLDOWN_CYCLES - 1) : '0;

  logic [2:0]        state_q,   state_d;
  logic [3:0]        hit_cnt_q, hit_cnt_d;
  logic              mover_q,   mover_d;
  logic              moving_q,  moving_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  logic [DATA_W-1:0] sample_u;
  logic [DATA_W-1:0] mag;
  logic              hit;
  logic              same_run;
  logic [3:0]        hit_next;

`ifdef GYRO_DIRECTION_EN
  logic              run_dir_q,   run_dir_d;
  logic              mover_dir_q, mover_dir_d;
  logic              sample_pos;
`endif

  // Magnitude with saturation: the most negative code has no positive twin,
  // so it clamps to the largest positive value instead of wrapping.
  always_comb begin
    sample_u = sample_data;
    if (!sample_u[DATA_W-1]) begin
      mag = sample_u;
    end else if (sample_u == MIN_NEG) begin
      mag = MAX_POS;
    end else begin
      mag = ZERO_D - sample_u;
    end
    hit = (mag > THR_L);
  end

`ifdef GYRO_DIRECTION_EN
  // Zero is never a hit, so sign bit clear means a strictly positive rate.
  assign sample_pos = ~sample_data[DATA_W-1];
  assign same_run   = (sample_pos == run_dir_q);
`else
  assign same_run   = 1'b1;
`endif

  assign hit_next = hit_cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    hit_cnt_d = hit_cnt_q;
    mover_d   = 1'b0;
    moving_d  = moving_q;
    cnt_d     = cnt_q;
`ifdef GYRO_DIRECTION_EN
    run_dir_d   = run_dir_q;
    mover_dir_d = mover_dir_q;
`endif

    if (!enable_giroscopio) begin
      // Enable outranks samples: a final hit in this cycle is discarded too.
      state_d   = S_IDLE;
      hit_cnt_d = 4'd0;
      moving_d  = 1'b0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_ARMED;
          hit_cnt_d = 4'd0;
          moving_d  = 1'b0;
        end

        S_ARMED: begin
          if (sample_valid && hit) begin
            hit_cnt_d = 4'd1;
`ifdef GYRO_DIRECTION_EN
            run_dir_d = sample_pos;
`endif
            if (HIT_L == 4'd1) begin
              state_d  = S_FIRE;
              mover_d  = 1'b1;
              moving_d = 1'b1;
`ifdef GYRO_DIRECTION_EN
              mover_dir_d = sample_pos;
`endif
            end else begin
              state_d = S_COUNTING;
            end
          end
        end

        S_COUNTING: begin
          if (sample_valid) begin
            if (!hit) begin
              hit_cnt_d = 4'd0;
              state_d   = S_ARMED;
            end else if (!same_run) begin
              // Opposite-sign hit starts a fresh run rather than clearing.
              hit_cnt_d = 4'd1;
`ifdef GYRO_DIRECTION_EN
              run_dir_d = sample_pos;
`endif
            end else begin
              hit_cnt_d = hit_next;
              if (hit_next == HIT_L) begin
                state_d  = S_FIRE;
                mover_d  = 1'b1;
                moving_d = 1'b1;
`ifdef GYRO_DIRECTION_EN
                mover_dir_d = run_dir_q;
`endif
              end
            end
          end
        end

        S_FIRE: begin
          hit_cnt_d = 4'd0;
          cnt_d     = CD_LOAD;
          moving_d  = 1'b1;
          state_d   = S_COOLDOWN;
        end

        S_COOLDOWN: begin
          // Samples are deliberately not looked at here.
          if (cnt_q == '0) begin
            state_d  = S_ARMED;
            moving_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        default: begin
          state_d   = S_IDLE;
          hit_cnt_d = 4'd0;
          moving_d  = 1'b0;
          cnt_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      hit_cnt_q <= 4'd0;
      mover_q   <= 1'b0;
      moving_q  <= 1'b0;
      cnt_q     <= '0;
`ifdef GYRO_DIRECTION_EN
      run_dir_q   <= 1'b0;
      mover_dir_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      hit_cnt_q <= hit_cnt_d;
      mover_q   <= mover_d;
      moving_q  <= moving_d;
      cnt_q     <= cnt_d;
`ifdef GYRO_DIRECTION_EN
      run_dir_q   <= run_dir_d;
      mover_dir_q <= mover_dir_d;
`endif
    end
  end

  assign mover   = mover_q;
  assign moving  = moving_q;
  assign hit_cnt = hit_cnt_q;
`ifdef GYRO_DIRECTION_EN
  assign mover_dir = mover_dir_q;
`endif

endmodule

// File: tb/tb_gyro_motion_detector.sv
// Purpose : directed self-checking bench for gyro_motion_detector (short cooldown).
// Latency : each driven cycle pushes its expected outputs; they are popped one edge later.
// Backpres: none; every wait on the DUT is bounded by a cycle budget.

module tb_gyro_motion_detector;

  localparam int CD = 100;

  logic               clk;
  logic               reset;
  logic               enable_giroscopio;
  logic               sample_valid;
  logic signed [15:0] sample_data;
  logic               mover;
  logic               moving;
  logic [3:0]         hit_cnt;
`ifdef GYRO_DIRECTION_EN
  logic               mover_dir;
`endif

  gyro_motion_detector #(
    .DATA_W(16), .THRESHOLD(2000), .HIT_COUNT(3),
    .COOLDOWN_CYCLES(CD), .CNT_W(25)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable_giroscopio(enable_giroscopio),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .mover(mover),
    .moving(moving),
`ifdef GYRO_DIRECTION_EN
    .mover_dir(mover_dir),
`endif
    .hit_cnt(hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] hc;
    logic       mv;
    logic       mg;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Pulse monitor on the falling edge, away from the active edge.
  int   mover_pulses = 0;
  int   consec       = 0;
  logic mover_prev   = 1'b0;
  always @(negedge clk) begin
    if (mover === 1'b1) mover_pulses++;
    if (mover === 1'b1 && mover_prev === 1'b1) consec++;
    mover_prev = mover;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, queue its expected outputs, then compare after the edge.
  task automatic cycle(input string tag, input logic sv, input int d,
                       input logic [3:0] hc, input logic mv, input logic mg);
    exp_t e;
    sample_valid = sv;
    sample_data  = 16'(d);
    sb.push_back('{tag, hc, mv, mg});
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    e = sb.pop_front();
    chk({e.tag, ".hit_cnt"}, 32'(hit_cnt), 32'(e.hc));
    chk({e.tag, ".mover"},   32'(mover),   32'(e.mv));
    chk({e.tag, ".moving"},  32'(moving),  32'(e.mg));
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts further moving-high cycles; bounded so a stuck DUT cannot hang.
  task automatic wait_cool(output int mh);
    mh = 0;
    for (int i = 0; i < 3 * CD; i++) begin
      @(posedge clk);
      #1;
      if (moving !== 1'b1) break;
      mh++;
    end
  endtask

  int mh;

  initial begin
    reset             = 1'b0;
    enable_giroscopio = 1'b1;
    sample_valid      = 1'b0;
    sample_data       = 16'sd0;

    // Reset outranks enable and samples.
    cycle("rst0", 1'b1, 5000, 4'd0, 1'b0, 1'b0);
    cycle("rst1", 1'b1, 5000, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    idle(2);

    // Basic fire: three hits of mixed sign, 10 cycles apart.
    cycle("t2_h1", 1'b1, 2500, 4'd1, 1'b0, 1'b0);
    idle(9);
`ifdef GYRO_DIRECTION_EN
    cycle("t2_h2", 1'b1, -3000, 4'd1, 1'b0, 1'b0);
    idle(9);
    cycle("t2_h3", 1'b1, 2100, 4'd1, 1'b0, 1'b0);
    cycle("t2_h4", 1'b1, 2200, 4'd2, 1'b0, 1'b0);
    cycle("t2_fire", 1'b1, 2300, 4'd3, 1'b1, 1'b1);
    chk("t2_dir", 32'(mover_dir), 32'd1);
`else
    cycle("t2_h2", 1'b1, -3000, 4'd2, 1'b0, 1'b0);
    idle(9);
    cycle("t2_fire", 1'b1, 2100, 4'd3, 1'b1, 1'b1);
`endif
    wait_cool(mh);
    chk("t2_moving_len", 32'(mh + 1), 32'(CD + 1));
    chk("t2_hit_after", 32'(hit_cnt), 32'd0);
    chk("t2_pulses", 32'(mover_pulses), 32'd1);

    // Equal-to-threshold is not a hit.
    cycle("t3_a", 1'b1, 2500, 4'd1, 1'b0, 1'b0);
    idle(2);
    cycle("t3_eq", 1'b1, 2000, 4'd0, 1'b0, 1'b0);
    idle(2);
    cycle("t3_b", 1'b1, 2500, 4'd1, 1'b0, 1'b0);
    cycle("t3_clr", 1'b1, 100, 4'd0, 1'b0, 1'b0);
    chk("t3_pulses", 32'(mover_pulses), 32'd1);

    // Most negative code saturates and counts as a hit.
    cycle("t4_n1", 1'b1, -32768, 4'd1, 1'b0, 1'b0);
    cycle("t4_n2", 1'b1, -32768, 4'd2, 1'b0, 1'b0);
    cycle("t4_fire", 1'b1, -32768, 4'd3, 1'b1, 1'b1);
`ifdef GYRO_DIRECTION_EN
    chk("t4_dir", 32'(mover_dir), 32'd0);
`endif
    // Samples during cooldown are ignored.
    for (int i = 0; i < 10; i++) begin
      cycle($sformatf("t4_cd%0d", i), 1'b1, 9000, 4'd0, 1'b0, 1'b1);
    end
    chk("t4_pulses", 32'(mover_pulses), 32'd2);
    wait_cool(mh);
    chk("t4_cool_end", 32'(moving), 32'd0);
    cycle("t4_r1", 1'b1, 3000, 4'd1, 1'b0, 1'b0);
    cycle("t4_r2", 1'b1, 3000, 4'd2, 1'b0, 1'b0);
    cycle("t4_rfire", 1'b1, 3000, 4'd3, 1'b1, 1'b1);
`ifdef GYRO_DIRECTION_EN
    chk("t4_rdir", 32'(mover_dir), 32'd1);
`endif
    wait_cool(mh);
    chk("t4_rcool_end", 32'(moving), 32'd0);
    chk("t4_rpulses", 32'(mover_pulses), 32'd3);

    // Enable drop flushes the partial count.
    cycle("t5_h1", 1'b1, 3000, 4'd1, 1'b0, 1'b0);
    cycle("t5_h2", 1'b1, 3000, 4'd2, 1'b0, 1'b0);
    enable_giroscopio = 1'b0;
    cycle("t5_dis", 1'b0, 0, 4'd0, 1'b0, 1'b0);
    enable_giroscopio = 1'b1;
    cycle("t5_reen", 1'b0, 0, 4'd0, 1'b0, 1'b0);
    cycle("t5_h1b", 1'b1, 3000, 4'd1, 1'b0, 1'b0);
    chk("t5_pulses", 32'(mover_pulses), 32'd3);

    // Final hit with enable dropping in the same cycle: no pulse.
    cycle("t5_h2b", 1'b1, 3000, 4'd2, 1'b0, 1'b0);
    enable_giroscopio = 1'b0;
    cycle("t5_sup", 1'b1, 3000, 4'd0, 1'b0, 1'b0);
    enable_giroscopio = 1'b1;
    idle(2);
    chk("t5_sup_pulses", 32'(mover_pulses), 32'd3);

    // Reset pulse in the middle of a cooldown.
    cycle("t6_h1", 1'b1, 3000, 4'd1, 1'b0, 1'b0);
    cycle("t6_h2", 1'b1, 3000, 4'd2, 1'b0, 1'b0);
    cycle("t6_fire", 1'b1, 3000, 4'd3, 1'b1, 1'b1);
    cycle("t6_cd", 1'b0, 0, 4'd0, 1'b0, 1'b1);
    idle(5);
    reset = 1'b0;
    cycle("t6_rst", 1'b0, 0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    idle(2);
    cycle("t6_after", 1'b1, 3000, 4'd1, 1'b0, 1'b0);
    chk("t6_pulses", 32'(mover_pulses), 32'd4);
    chk("no_back_to_back", 32'(consec), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
